data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 25 ++
 rtl/data_mem_ctrl_if.sv | 30 +++
 rtl/data_mem_ctrl_byte_lane_map.sv | 24 ++
 rtl/data_mem_ctrl.sv | 112 +++++++++++
 tb/tb_data_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants for the byte-addressed data memory controller:
// FSM state encoding, request address width and the range-check helper.
package data_mem_ctrl_pkg;

    localparam int ADDR_W = 24;

    typedef logic [1:0]      state_t;
    typedef logic [ADDR_W:0] addr_sum_t;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The end address is formed one bit wider so a start near 0xFFFFFF cannot wrap into range.
    function automatic logic addr_out_of_range(
        input logic [ADDR_W-1:0] addr,
        input int                word_bytes,
        input int                depth_bytes
    );
        addr_sum_t end_addr;
        end_addr = {1'b0, addr} + addr_sum_t'(word_bytes);
        return end_addr > addr_sum_t'(depth_bytes);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller; master drives requests,
// slave (the controller) returns one response per accepted request.
interface data_mem_ctrl_if
    import data_mem_ctrl_pkg::*;
#(
    parameter int WORD_BYTES = 3
) ();

    logic                    ReqValid;
    logic                    ReqReady;
    logic                    ReqWrite;
    logic [ADDR_W-1:0]       Address;
    logic [8*WORD_BYTES-1:0] WriteData;
    logic [WORD_BYTES-1:0]   ByteEnable;
    logic                    RespValid;
    logic                    RespReady;
    logic [8*WORD_BYTES-1:0] ReadData;
    logic                    AccessError;

    modport master (
        output ReqValid, ReqWrite, Address, WriteData, ByteEnable, RespReady,
        input  ReqReady, RespValid, ReadData, AccessError
    );

    modport slave (
        input  ReqValid, ReqWrite, Address, WriteData, ByteEnable, RespReady,
        output ReqReady, RespValid, ReadData, AccessError
    );

endinterface

// File: rtl/data_mem_ctrl_byte_lane_map.sv
// Permutes lanes between data-word order and ascending address-offset order.
// Both mappings are their own inverse, so one block serves read and write paths.
module byte_lane_map #(
    parameter int LANES      = 3,
    parameter int LANE_BITS  = 8,
    parameter int BIG_ENDIAN = 1
) (
    input  logic [LANES*LANE_BITS-1:0] lanes_in,
    output logic [LANES*LANE_BITS-1:0] lanes_out
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (BIG_ENDIAN != 0) begin : g_big
                assign lanes_out[gi*LANE_BITS +: LANE_BITS] =
                    lanes_in[(LANES-1-gi)*LANE_BITS +: LANE_BITS];
            end else begin : g_little
                assign lanes_out[gi*LANE_BITS +: LANE_BITS] =
                    lanes_in[gi*LANE_BITS +: LANE_BITS];
            end
        end
    endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with unaligned multi-byte word access, per-byte
// write enables, out-of-range error responses and a self-clearing init phase.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int WORD_BYTES  = 3,
    parameter int DEPTH_BYTES = 128,
    parameter int BIG_ENDIAN  = 1
) (
    input logic           Clock,
    input logic           Reset,
    data_mem_ctrl_if.slave bus
);

    localparam int DW = 8 * WORD_BYTES;
    localparam int IW = $clog2(DEPTH_BYTES);

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   init_cnt_reg;
    logic [DW-1:0]   rdata_reg;
    logic            err_reg;

    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic            range_err;
    logic            init_last;
    logic            do_write;
    logic [IW-1:0]   lane_idx [WORD_BYTES];
    logic [DW-1:0]   wr_lanes;
    logic [WORD_BYTES-1:0] be_lanes;
    logic [DW-1:0]   rd_lanes;
    logic [DW-1:0]   rd_word;

    assign accept    = bus.ReqValid && (state_reg == ST_IDLE);
    assign range_err = addr_out_of_range(bus.Address, WORD_BYTES, DEPTH_BYTES);
    assign init_last = (init_cnt_reg == IW'(DEPTH_BYTES - 1));
    assign do_write  = accept && bus.ReqWrite && !range_err;

    byte_lane_map #(.LANES(WORD_BYTES), .LANE_BITS(8), .BIG_ENDIAN(BIG_ENDIAN)) u_wr_map (
        .lanes_in  (bus.WriteData),
        .lanes_out (wr_lanes)
    );

    byte_lane_map #(.LANES(WORD_BYTES), .LANE_BITS(1), .BIG_ENDIAN(BIG_ENDIAN)) u_be_map (
        .lanes_in  (bus.ByteEnable),
        .lanes_out (be_lanes)
    );

    byte_lane_map #(.LANES(WORD_BYTES), .LANE_BITS(8), .BIG_ENDIAN(BIG_ENDIAN)) u_rd_map (
        .lanes_in  (rd_lanes),
        .lanes_out (rd_word)
    );

    // Lane gi sits at Address+gi; indices only matter for in-range accesses, where no wrap occurs.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_addr
            assign lane_idx[gi]          = bus.Address[IW-1:0] + IW'(gi);
            assign rd_lanes[gi*8 +: 8]   = mem[lane_idx[gi]];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: if (init_last)     state_next = ST_IDLE;
            ST_IDLE: if (accept)        state_next = ST_RESP;
            ST_RESP: if (bus.RespReady) state_next = ST_IDLE;
            default:                    state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                init_cnt_reg <= init_last ? '0 : init_cnt_reg + 1'b1;
            end
            if (accept) begin
                err_reg   <= range_err;
                rdata_reg <= (!bus.ReqWrite && !range_err) ? rd_word : '0;
            end
        end
    end

    // Storage carries no reset of its own; the INIT sweep is what defines its contents.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state_reg == ST_INIT) begin
                mem[init_cnt_reg] <= 8'h00;
            end else if (do_write) begin
                for (int k = 0; k < WORD_BYTES; k++) begin
                    if (be_lanes[k]) begin
                        mem[lane_idx[k]] <= wr_lanes[k*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.ReqReady    = (state_reg == ST_IDLE);
    assign bus.RespValid   = (state_reg == ST_RESP);
    assign bus.ReadData    = rdata_reg;
    assign bus.AccessError = err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (default parameters: 3-byte words, 128 bytes, big-endian).
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic srst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.WORD_BYTES(3)) bus ();

    data_mem_ctrl #(.WORD_BYTES(3), .DEPTH_BYTES(128), .BIG_ENDIAN(1)) dut (
        .Clock (clk),
        .Reset (srst),
        .bus   (bus)
    );

    // Called at a negedge; returns the response seen one cycle after the accept edge.
    task automatic do_access(input logic wr, input logic [23:0] addr, input logic [23:0] wdata,
                             input logic [2:0] be, output logic [23:0] rdata,
                             output logic err, output logic rv);
        int waited = 0;
        bus.ReqValid   = 1'b1;
        bus.ReqWrite   = wr;
        bus.Address    = addr;
        bus.WriteData  = wdata;
        bus.ByteEnable = be;
        while (bus.ReqReady !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (bus.ReqReady !== 1'b1) begin
            checks++;
            $display("FAIL req_timeout addr=%06h: ReqReady never rose in 500 cycles", addr);
            bus.ReqValid = 1'b0;
            rdata = '0;
            err = 1'b0;
            rv = 1'b0;
            return;
        end
        @(negedge clk);
        bus.ReqValid  = 1'b0;
        rv            = bus.RespValid;
        rdata         = bus.ReadData;
        err           = bus.AccessError;
        bus.RespReady = 1'b1;
        @(negedge clk);
        bus.RespReady = 1'b0;
        $display("txn %s addr=%06h wdata=%06h be=%03b -> rv=%0b rdata=%06h err=%0b",
                 wr ? "WR" : "RD", addr, wdata, be, rv, rdata, err);
    endtask

    // Counts clock edges from reset release until ReqReady is seen high.
    task automatic count_init(output int n);
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.ReqReady === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        logic [23:0] d;
        logic        e, rv;
        int          n;
        srst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ReqReady, bus.RespValid, bus.AccessError} !== 3'b000) begin
            $display("FAIL reset_flags: got ReqReady/RespValid/AccessError=%03b, want 000",
                     {bus.ReqReady, bus.RespValid, bus.AccessError});
        end else passed++;
        checks++;
        if (bus.ReadData !== 24'h0) $display("FAIL reset_rdata: got %06h, want 000000", bus.ReadData);
        else passed++;
        srst = 1'b0;
        count_init(n);
        checks++;
        if (n !== 128) $display("FAIL init_length: got %0d cycles, want 128", n);
        else passed++;
        do_access(1'b0, 24'h000000, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (rv !== 1'b1 || e !== 1'b0 || d !== 24'h000000)
            $display("FAIL read_after_init: got rv=%0b err=%0b data=%06h, want 1 0 000000", rv, e, d);
        else passed++;
    endtask

    task automatic test_write_read();
        logic [23:0] d;
        logic        e, rv;
        do_access(1'b1, 24'h000004, 24'hA1B2C3, 3'b111, d, e, rv);
        checks++;
        if (rv !== 1'b1 || e !== 1'b0 || d !== 24'h000000)
            $display("FAIL write_resp: got rv=%0b err=%0b data=%06h, want 1 0 000000", rv, e, d);
        else passed++;
        do_access(1'b0, 24'h000004, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (rv !== 1'b1 || e !== 1'b0 || d !== 24'hA1B2C3)
            $display("FAIL read_aligned: got rv=%0b err=%0b data=%06h, want 1 0 A1B2C3", rv, e, d);
        else passed++;
        do_access(1'b0, 24'h000005, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (d !== 24'hB2C300) $display("FAIL read_offset: got %06h, want B2C300", d);
        else passed++;
    endtask

    task automatic test_byte_enable();
        logic [23:0] d;
        logic        e, rv;
        do_access(1'b1, 24'h000010, 24'hAABBCC, 3'b111, d, e, rv);
        do_access(1'b1, 24'h000010, 24'h112233, 3'b101, d, e, rv);
        do_access(1'b0, 24'h000010, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (d !== 24'h11BB33) $display("FAIL byte_enable: got %06h, want 11BB33", d);
        else passed++;
    endtask

    task automatic test_range_error();
        logic [23:0] d;
        logic        e, rv;
        do_access(1'b1, 24'h00007D, 24'h010203, 3'b111, d, e, rv);
        checks++;
        if (e !== 1'b0) $display("FAIL last_word_in_range: got err=%0b, want 0", e);
        else passed++;
        do_access(1'b0, 24'h00007E, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (rv !== 1'b1 || e !== 1'b1 || d !== 24'h0)
            $display("FAIL read_7e_error: got rv=%0b err=%0b data=%06h, want 1 1 000000", rv, e, d);
        else passed++;
        do_access(1'b1, 24'h00007E, 24'hFFFFFF, 3'b111, d, e, rv);
        checks++;
        if (e !== 1'b1) $display("FAIL write_7e_error: got err=%0b, want 1", e);
        else passed++;
        do_access(1'b0, 24'h00007D, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (d !== 24'h010203) $display("FAIL error_write_no_effect: got %06h, want 010203", d);
        else passed++;
        do_access(1'b0, 24'hFFFFFF, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (e !== 1'b1 || d !== 24'h0)
            $display("FAIL addr_ffffff_error: got err=%0b data=%06h, want 1 000000", e, d);
        else passed++;
    endtask

    task automatic test_overlap();
        logic [23:0] d;
        logic        e, rv;
        do_access(1'b1, 24'h000020, 24'h445566, 3'b111, d, e, rv);
        do_access(1'b1, 24'h000023, 24'h778899, 3'b111, d, e, rv);
        do_access(1'b0, 24'h000021, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (d !== 24'h556677) $display("FAIL overlap_mix: got %06h, want 556677", d);
        else passed++;
    endtask

    task automatic test_stall();
        logic [23:0] d;
        logic        e, rv;
        int          ok_cycles = 0;
        bus.ReqValid   = 1'b1;
        bus.ReqWrite   = 1'b0;
        bus.Address    = 24'h000004;
        bus.ByteEnable = 3'b000;
        @(negedge clk);
        // Keep a competing write pending while the response is back-pressured.
        bus.ReqWrite   = 1'b1;
        bus.Address    = 24'h000000;
        bus.WriteData  = 24'hFFFFFF;
        bus.ByteEnable = 3'b111;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.RespValid !== 1'b1 || bus.ReadData !== 24'hA1B2C3 || bus.ReqReady !== 1'b0)
                $display("FAIL stall_hold_%0d: got rv=%0b data=%06h rdy=%0b, want 1 A1B2C3 0",
                         i, bus.RespValid, bus.ReadData, bus.ReqReady);
            else begin
                passed++;
                ok_cycles++;
            end
            @(negedge clk);
        end
        $display("txn RD addr=000004 stalled 5 cycles, %0d held", ok_cycles);
        bus.ReqValid  = 1'b0;
        bus.RespReady = 1'b1;
        @(negedge clk);
        bus.RespReady = 1'b0;
        do_access(1'b0, 24'h000000, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (d !== 24'h000000) $display("FAIL stall_req_ignored: got %06h, want 000000", d);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [23:0] d;
        logic        e, rv;
        int          n;
        do_access(1'b1, 24'h000004, 24'hA1B2C3, 3'b111, d, e, rv);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.Address  = 24'h000004;
        @(negedge clk);
        bus.ReqValid = 1'b0;
        checks++;
        if (bus.RespValid !== 1'b1) $display("FAIL resp_before_reset: got rv=%0b, want 1", bus.RespValid);
        else passed++;
        srst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.RespValid !== 1'b0 || bus.ReqReady !== 1'b0)
            $display("FAIL reset_in_resp: got rv=%0b rdy=%0b, want 0 0", bus.RespValid, bus.ReqReady);
        else passed++;
        srst = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (bus.ReqReady !== 1'b0) $display("FAIL mid_init_ready: got %0b, want 0", bus.ReqReady);
        else passed++;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        count_init(n);
        checks++;
        if (n !== 128) $display("FAIL reinit_length: got %0d cycles, want 128", n);
        else passed++;
        do_access(1'b0, 24'h000004, 24'h0, 3'b000, d, e, rv);
        checks++;
        if (rv !== 1'b1 || d !== 24'h000000)
            $display("FAIL cleared_after_reset: got rv=%0b data=%06h, want 1 000000", rv, d);
        else passed++;
    endtask

    initial begin
        bus.ReqValid   = 1'b0;
        bus.ReqWrite   = 1'b0;
        bus.Address    = '0;
        bus.WriteData  = '0;
        bus.ByteEnable = '0;
        bus.RespReady  = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_range_error();
        test_overlap();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
